// File: rtl/ysyx_22040127_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: IF->ID bus width,
// default reset PC, FSM state encodings and small bus/PC helpers.
package ysyx_22040127_fetch_pkg;

  // {inst[31:0], pc[31:0]}, instruction in the upper half
  localparam int IF_TO_ID_WIDTH = 64;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  // Fetch FSM encodings (kept as plain constants for legacy compatibility)
  localparam logic [0:0] S_REQ  = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  // Sequential successor of a fetch PC (fixed 4-byte instructions)
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Pack an instruction and its PC into the IF->ID bus layout
  function automatic logic [IF_TO_ID_WIDTH-1:0] pack_if_bus(input logic [31:0] inst,
                                                             input logic [31:0] pc);
    return {inst, pc};
  endfunction

endpackage

// File: rtl/ysyx_22040127_fetch_slot.sv
// Single-entry output register between fetch and decode: a valid bit plus
// the bus payload, with load / consume / kill controls. Written as a
// standalone block so it can later be replicated into a deeper fetch buffer.
module ysyx_22040127_fetch_slot
  import ysyx_22040127_fetch_pkg::*;
#(
  parameter int W = IF_TO_ID_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         consume,
  input  logic         kill,
  input  logic [W-1:0] load_bus,
  output logic         valid,
  output logic [W-1:0] bus
);

  logic         valid_q;
  logic [W-1:0] bus_q;

  // Occupancy: kill dominates, a load refills even if the old entry leaves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (kill) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
    end else if (consume) begin
      valid_q <= 1'b0;
    end
  end

  // Payload: only written on load, so a stalled entry stays stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_q <= '0;
    end else if (load) begin
      bus_q <= load_bus;
    end
  end

  assign valid = valid_q;
  assign bus   = bus_q;

endmodule

// File: rtl/ysyx_22040127_fetch.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding requests to
// instruction memory and presents each returned instruction with its PC on the
// IF->ID valid/allowin interface. Taken branches/jumps from ID redirect the PC,
// kill the output slot and discard any wrong-path response still in flight.
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt.
module ysyx_22040127_fetch
  import ysyx_22040127_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_allowin,
  output logic                      if_to_id_valid,
  output logic [IF_TO_ID_WIDTH-1:0] if_to_id_bus,
  input  logic                      id_branch_fire,
  input  logic                      id_branch_taken,
  input  logic [31:0]               id_branch_result,
  output logic                      imem_req_valid,
  input  logic                      imem_req_ready,
  output logic [31:0]               imem_req_addr,
  input  logic                      imem_resp_valid,
  input  logic [31:0]               imem_resp_data
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [63:0]               perf_fetch_cnt,
  output logic [63:0]               perf_stall_cnt
`endif
);

  logic [0:0]  state_q;
  logic [0:0]  state_d;
  logic [31:0] pc_q;
  logic [31:0] req_pc_q;
  logic        drop_q;
  logic        out_valid_q;

  logic        redirect;
  logic        out_fire;
  logic        can_issue;
  logic        req_fire;
  logic        resp_take;
  logic        slot_load;
  logic        in_req;
  logic        in_wait;

  assign in_req  = (state_q == S_REQ);
  assign in_wait = (state_q == S_WAIT);

  // A taken control transfer leaving ID makes everything younger wrong-path
  assign redirect = id_branch_fire & id_branch_taken;

  // The slot is hidden combinationally in the redirect cycle so ID never
  // sees the wrong-path instruction
  assign if_to_id_valid = out_valid_q & ~redirect;
  assign out_fire       = if_to_id_valid & id_allowin;

  // Only fetch when the result has somewhere to go: slot empty or draining now
  assign can_issue      = ~out_valid_q | out_fire;
  assign imem_req_valid = ~rst & in_req & can_issue;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // Responses are only meaningful while waiting; one arriving in S_REQ is a
  // leftover from before a reset and is ignored
  assign resp_take = in_wait & imem_resp_valid;
  assign slot_load = resp_take & ~drop_q & ~redirect;

  // Next-state: request accepted -> wait, response returned -> request again
  always_comb begin
    state_d = state_q;
    if (in_req) begin
      if (req_fire) state_d = S_WAIT;
    end else begin
      if (imem_resp_valid) state_d = S_REQ;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // PC: redirect wins over the sequential advance of an accepted request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (redirect) begin
      pc_q <= id_branch_result;
    end else if (req_fire) begin
      pc_q <= next_seq_pc(pc_q);
    end
  end

  // PC of the outstanding request, paired with its instruction on return
  always_ff @(posedge clk) begin
    if (req_fire) begin
      req_pc_q <= pc_q;
    end
  end

  // Drop flag: marks the outstanding request as wrong-path when a redirect
  // arrives before its response; a response in the redirect cycle itself is
  // discarded directly through slot_load instead
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= 1'b0;
    end else if (resp_take) begin
      drop_q <= 1'b0;
    end else if (redirect && (req_fire || in_wait)) begin
      drop_q <= 1'b1;
    end
  end

  ysyx_22040127_fetch_slot #(
    .W (IF_TO_ID_WIDTH)
  ) u_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (slot_load),
    .consume  (out_fire),
    .kill     (redirect),
    .load_bus (pack_if_bus(imem_resp_data, req_pc_q)),
    .valid    (out_valid_q),
    .bus      (if_to_id_bus)
  );

`ifdef FETCH_PERF_CNT_EN
  // Delivered-instruction counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= 64'd0;
    end else if (out_fire) begin
      perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
    end
  end

  // Backpressure counter: slot full but decode not accepting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= 64'd0;
    end else if (out_valid_q && !id_allowin) begin
      perf_stall_cnt <= perf_stall_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22040127_fetch.sv
// Self-checking bench for the instruction-fetch stage: a cycle table for the
// steady-state and stall behaviour, a scoreboard of expected PCs popped on
// every IF->ID transfer, and hand-written redirect / reset sequences.
module tb_ysyx_22040127_fetch;
  import ysyx_22040127_fetch_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      id_allowin;
  logic                      if_to_id_valid;
  logic [IF_TO_ID_WIDTH-1:0] if_to_id_bus;
  logic                      id_branch_fire;
  logic                      id_branch_taken;
  logic [31:0]               id_branch_result;
  logic                      imem_req_valid;
  logic                      imem_req_ready;
  logic [31:0]               imem_req_addr;
  logic                      imem_resp_valid;
  logic [31:0]               imem_resp_data;
`ifdef FETCH_PERF_CNT_EN
  logic [63:0]               perf_fetch_cnt;
  logic [63:0]               perf_stall_cnt;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  int          resp_lat;
  int          resp_cnt;
  logic [31:0] resp_addr;
  logic        last_hs;
  logic [31:0] last_hs_addr;
  int          fires_seen;

  typedef struct {
    logic        allowin;
    logic        req_v;
    logic [31:0] req_a;
    logic        out_v;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl[14];

  always #5 clk = ~clk;

  ysyx_22040127_fetch dut (
    .clk              (clk),
    .rst              (rst),
    .id_allowin       (id_allowin),
    .if_to_id_valid   (if_to_id_valid),
    .if_to_id_bus     (if_to_id_bus),
    .id_branch_fire   (id_branch_fire),
    .id_branch_taken  (id_branch_taken),
    .id_branch_result (id_branch_result),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_resp_valid  (imem_resp_valid),
    .imem_resp_data   (imem_resp_data)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt   (perf_fetch_cnt),
    .perf_stall_cnt   (perf_stall_cnt)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: sample outputs at negedge (scoreboard + handshake capture),
  // then advance the memory model just after posedge
  task automatic step();
    logic [31:0] pc;
    @(negedge clk);
    last_hs      = imem_req_valid & imem_req_ready;
    last_hs_addr = imem_req_addr;
    if (if_to_id_valid && id_allowin) begin
      fires_seen++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got bus %h expected no transfer", if_to_id_bus);
      end else begin
        pc = exp_q.pop_front();
        check("sb_bus", if_to_id_bus, {~pc, pc});
      end
    end
    @(posedge clk);
    #1;
    if (last_hs) begin
      resp_cnt  = resp_lat;
      resp_addr = last_hs_addr;
    end else if (resp_cnt > 0) begin
      resp_cnt--;
    end
    imem_resp_valid = (resp_cnt == 1);
    imem_resp_data  = ~resp_addr;
  endtask

  task automatic wait_hs(input string name);
    int n = 0;
    while (!last_hs && n < 40) begin
      step();
      n++;
    end
    check({name, "_hs_seen"}, 64'(last_hs), 64'd1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      step();
      n++;
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic set_branch(input logic en, input logic [31:0] tgt);
    id_branch_fire   = en;
    id_branch_taken  = en;
    id_branch_result = tgt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // cycle table after reset release: allowin, req_valid, req_addr, out_valid, bus pc
    tbl[0]  = '{1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 32'h8000_0004, 1'b1, 32'h8000_0000};
    tbl[3]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
    tbl[4]  = '{1'b1, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0004};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0008};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0008};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0008};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0008};
    tbl[10] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0008};
    tbl[11] = '{1'b1, 1'b1, 32'h8000_000C, 1'b1, 32'h8000_0008};
    tbl[12] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
    tbl[13] = '{1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_000C};

    rst             = 1'b1;
    id_allowin      = 1'b1;
    set_branch(1'b0, 32'h0);
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    resp_lat        = 1;
    resp_cnt        = 0;
    resp_addr       = 32'h0;
    last_hs         = 1'b0;
    last_hs_addr    = 32'h0;
    fires_seen      = 0;

    #2;
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_out_valid", 64'(if_to_id_valid), 64'd0);
    check("rst_bus",       if_to_id_bus,        64'd0);
    step();
    step();
    rst = 1'b0;

    // steady-state fetch and a 5-cycle decode stall
    exp_q.push_back(32'h8000_0000);
    exp_q.push_back(32'h8000_0004);
    exp_q.push_back(32'h8000_0008);
    exp_q.push_back(32'h8000_000C);
    for (int i = 0; i < 14; i++) begin
      id_allowin = tbl[i].allowin;
      #2;
      check($sformatf("tbl%0d_req_valid", i), 64'(imem_req_valid), 64'(tbl[i].req_v));
      if (tbl[i].req_v) check($sformatf("tbl%0d_req_addr", i), 64'(imem_req_addr), 64'(tbl[i].req_a));
      check($sformatf("tbl%0d_out_valid", i), 64'(if_to_id_valid), 64'(tbl[i].out_v));
      if (tbl[i].out_v) check($sformatf("tbl%0d_bus", i), if_to_id_bus, {~tbl[i].pc, tbl[i].pc});
      step();
    end

    // redirect while the slot is full and ID is accepting
    step();
    set_branch(1'b1, 32'h8000_0200);
    #2;
    check("t4_valid_killed", 64'(if_to_id_valid), 64'd0);
    check("t4_no_req",       64'(imem_req_valid), 64'd0);
    step();
    set_branch(1'b0, 32'h0);
    exp_q.push_back(32'h8000_0200);
    #2;
    check("t4_req_valid", 64'(imem_req_valid), 64'd1);
    check("t4_req_addr",  64'(imem_req_addr),  64'h8000_0200);
    resp_lat = 3;
    wait_drain("t4");

    // redirect while waiting on a slow response
    check("t3_in_wait_hs", 64'(last_hs), 64'd1);
    set_branch(1'b1, 32'h8000_0100);
    #2;
    check("t3_no_req_in_wait", 64'(imem_req_valid), 64'd0);
    step();
    set_branch(1'b0, 32'h0);
    resp_lat = 1;
    exp_q.push_back(32'h8000_0100);
    wait_hs("t3");
    check("t3_req_addr", 64'(last_hs_addr), 64'h8000_0100);

    // hold ready low so a request waits with the slot empty
    imem_req_ready = 1'b0;
    step();
    step();
    step();
    step();
    check("t5_pre_drained", 64'(exp_q.size()), 64'd0);
    check("t5_pre_req_valid", 64'(imem_req_valid), 64'd1);
    check("t5_pre_req_addr",  64'(imem_req_addr),  64'h8000_0104);

    // redirect in the same cycle the request is accepted
    imem_req_ready = 1'b1;
    set_branch(1'b1, 32'h8000_0300);
    #2;
    check("t5_req_with_redirect", 64'(imem_req_valid), 64'd1);
    step();
    check("t5_hs", 64'(last_hs), 64'd1);
    set_branch(1'b0, 32'h0);
    exp_q.push_back(32'h8000_0300);
    step();
    wait_hs("t5");
    check("t5_req_addr", 64'(last_hs_addr), 64'h8000_0300);

    // reset while a slow response is outstanding
    resp_lat = 4;
    wait_drain("t6_pre");
    check("t6_pre_hs", 64'(last_hs), 64'd1);
    step();
    rst = 1'b1;
    #2;
    check("t6_rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("t6_rst_out_valid", 64'(if_to_id_valid), 64'd0);
    check("t6_rst_bus",       if_to_id_bus,        64'd0);
    exp_q.delete();
    fires_seen = 0;
    step();
    rst            = 1'b0;
    imem_req_ready = 1'b0;
    resp_lat       = 1;
    #2;
    check("t6_first_req_valid", 64'(imem_req_valid), 64'd1);
    check("t6_first_req_addr",  64'(imem_req_addr),  64'h8000_0000);
    step();
    #2;
    check("t6_stale_resp_seen", 64'(imem_resp_valid), 64'd1);
    check("t6_stale_req_addr",  64'(imem_req_addr),   64'h8000_0000);
    step();
    check("t6_stale_not_loaded", 64'(if_to_id_valid), 64'd0);
    imem_req_ready = 1'b1;
    exp_q.push_back(32'h8000_0000);
    wait_hs("t6");
    check("t6_req_addr", 64'(last_hs_addr), 64'h8000_0000);
    wait_drain("t6");

`ifdef FETCH_PERF_CNT_EN
    check("perf_fetch_cnt", perf_fetch_cnt, 64'(fires_seen));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
